// File: rtl/vga_sync_timing.sv
// Raster timing generator: pixel/line counters, sync, display enable and start strobes.
// Each output is registered from the next raster position, so they all describe the same pixel.
module vga_sync_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COORD_W  = 11
) (
  input  logic               i_clk,
  input  logic               i_rst_l,
  input  logic               i_pix_ce_h,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_de_h,
  output logic               o_hs_h,
  output logic               o_vs_h,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_line_start_h,
  output logic               o_frame_start_h
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

  // Pin level while sync is asserted; the idle level is its complement.
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic               x_wrap;
  logic [COORD_W-1:0] x_nxt;
  logic [COORD_W-1:0] y_nxt;
  logic               de_nxt;
  logic               hs_nxt;
  logic               vs_nxt;
  logic               line_nxt;
  logic               frame_nxt;

  always_comb begin
    x_wrap    = (o_x == X_LAST);
    x_nxt     = x_wrap ? '0 : (o_x + ONE);
    y_nxt     = o_y;
    if (x_wrap) begin
      y_nxt = (o_y == Y_LAST) ? '0 : (o_y + ONE);
    end
    de_nxt    = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    hs_nxt    = (x_nxt >= HS_START) && (x_nxt < HS_END);
    vs_nxt    = (y_nxt >= VS_START) && (y_nxt < VS_END);
    line_nxt  = (x_nxt == '0);
    frame_nxt = (x_nxt == '0) && (y_nxt == '0);
  end

  // Levels advance only on a pixel step; strobes drop on any edge so they stay one clock wide.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      o_x             <= X_LAST;
      o_y             <= Y_LAST;
      o_de_h          <= 1'b0;
      o_hs_h          <= 1'b0;
      o_vs_h          <= 1'b0;
      o_hsync         <= ~HS_ACT;
      o_vsync         <= ~VS_ACT;
      o_line_start_h  <= 1'b0;
      o_frame_start_h <= 1'b0;
    end else if (i_pix_ce_h) begin
      o_x             <= x_nxt;
      o_y             <= y_nxt;
      o_de_h          <= de_nxt;
      o_hs_h          <= hs_nxt;
      o_vs_h          <= vs_nxt;
      o_hsync         <= hs_nxt ~^ HS_ACT;
      o_vsync         <= vs_nxt ~^ VS_ACT;
      o_line_start_h  <= line_nxt;
      o_frame_start_h <= frame_nxt;
    end else begin
      o_line_start_h  <= 1'b0;
      o_frame_start_h <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing: a full-size instance plus a small, inverted-polarity instance
// sharing stimulus, both compared each cycle against a frame-index reference model.
module tb_vga_sync_timing;

  typedef struct {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int hpol; int vpol;
  } tim_t;

  typedef struct {
    int x; int y; int de; int hs_h; int vs_h;
    int hsync; int vsync; int ls; int fs;
  } obs_t;

  typedef struct {
    bit rst; bit ce;
    int x; int y; int de; int ls; int fs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        ce_h = 1'b0;

  logic [10:0] a_x, a_y, b_x, b_y;
  logic        a_de, a_hs, a_vs, a_hsync, a_vsync, a_ls, a_fs;
  logic        b_de, b_hs, b_vs, b_hsync, b_vsync, b_ls, b_fs;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pa, pb;
  bit stepped = 1'b0;
  tim_t ta, tb;

  always #5 clk = ~clk;

  vga_sync_timing dut_a (
    .i_clk(clk), .i_rst_l(rst_l), .i_pix_ce_h(ce_h),
    .o_x(a_x), .o_y(a_y), .o_de_h(a_de), .o_hs_h(a_hs), .o_vs_h(a_vs),
    .o_hsync(a_hsync), .o_vsync(a_vsync),
    .o_line_start_h(a_ls), .o_frame_start_h(a_fs)
  );

  vga_sync_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1), .VS_POL(1), .COORD_W(11)
  ) dut_b (
    .i_clk(clk), .i_rst_l(rst_l), .i_pix_ce_h(ce_h),
    .o_x(b_x), .o_y(b_y), .o_de_h(b_de), .o_hs_h(b_hs), .o_vs_h(b_vs),
    .o_hsync(b_hsync), .o_vsync(b_vsync),
    .o_line_start_h(b_ls), .o_frame_start_h(b_fs)
  );

  function automatic int htot(input tim_t t);
    return t.ha + t.hf + t.hs + t.hb;
  endfunction

  function automatic int ftot(input tim_t t);
    return htot(t) * (t.va + t.vf + t.vs + t.vb);
  endfunction

  // Position p is the pixel index within the frame; everything else follows from the timing rules.
  function automatic obs_t model(input tim_t t, input int p, input bit st);
    obs_t o;
    o.x     = p % htot(t);
    o.y     = p / htot(t);
    o.de    = (o.x < t.ha && o.y < t.va) ? 1 : 0;
    o.hs_h  = (o.x >= t.ha + t.hf && o.x < t.ha + t.hf + t.hs) ? 1 : 0;
    o.vs_h  = (o.y >= t.va + t.vf && o.y < t.va + t.vf + t.vs) ? 1 : 0;
    o.hsync = (o.hs_h == t.hpol) ? 1 : 0;
    o.vsync = (o.vs_h == t.vpol) ? 1 : 0;
    o.ls    = (st && o.x == 0) ? 1 : 0;
    o.fs    = (st && p == 0) ? 1 : 0;
    return o;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_models();
    obs_t oa, ob;
    oa = model(ta, pa, stepped);
    ob = model(tb, pb, stepped);
    cmp("a_x", int'(a_x), oa.x);        cmp("a_y", int'(a_y), oa.y);
    cmp("a_de", int'(a_de), oa.de);     cmp("a_hs_h", int'(a_hs), oa.hs_h);
    cmp("a_vs_h", int'(a_vs), oa.vs_h); cmp("a_hsync", int'(a_hsync), oa.hsync);
    cmp("a_vsync", int'(a_vsync), oa.vsync);
    cmp("a_line_start", int'(a_ls), oa.ls); cmp("a_frame_start", int'(a_fs), oa.fs);
    cmp("b_x", int'(b_x), ob.x);        cmp("b_y", int'(b_y), ob.y);
    cmp("b_de", int'(b_de), ob.de);     cmp("b_hs_h", int'(b_hs), ob.hs_h);
    cmp("b_vs_h", int'(b_vs), ob.vs_h); cmp("b_hsync", int'(b_hsync), ob.hsync);
    cmp("b_vsync", int'(b_vsync), ob.vsync);
    cmp("b_line_start", int'(b_ls), ob.ls); cmp("b_frame_start", int'(b_fs), ob.fs);
  endtask

  task automatic model_reset();
    pa = ftot(ta) - 1;
    pb = ftot(tb) - 1;
    stepped = 1'b0;
  endtask

  // Drive inputs (just after a falling edge), take one rising edge, check on the next falling edge.
  task automatic cycle(input bit rst, input bit ce);
    rst_l = rst;
    ce_h  = ce;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_reset();
    end else if (ce) begin
      pa = (pa + 1) % ftot(ta);
      pb = (pb + 1) % ftot(tb);
      stepped = 1'b1;
    end else begin
      stepped = 1'b0;
    end
    @(negedge clk);
    check_models();
  endtask

  initial begin
    vec_t tbl[6];
    int de_cnt, hl_cnt, vs_cnt, ls_last, ls_n, fs_last, fs_n, seek;

    ta = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
    tb = '{8, 2, 3, 2, 4, 1, 2, 2, 1, 1};
    model_reset();

    // Small instance: 15 pixels per line, 9 lines per frame.
    tbl[0] = '{1'b0, 1'b1, 14, 8, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 14, 8, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 0, 0, 1, 1, 1};
    tbl[3] = '{1'b1, 1'b0, 0, 0, 1, 0, 0};
    tbl[4] = '{1'b1, 1'b1, 1, 0, 1, 0, 0};
    tbl[5] = '{1'b1, 1'b1, 2, 0, 1, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].rst, tbl[i].ce);
      cmp("tbl_x", int'(b_x), tbl[i].x);
      cmp("tbl_y", int'(b_y), tbl[i].y);
      cmp("tbl_de", int'(b_de), tbl[i].de);
      cmp("tbl_line_start", int'(b_ls), tbl[i].ls);
      cmp("tbl_frame_start", int'(b_fs), tbl[i].fs);
    end

    // Line wrap on the small instance: x 2 -> 14 is 12 steps, then the wrap into y=1.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1);
    cmp("wrap_pre_x", int'(b_x), 14);
    cycle(1'b1, 1'b1);
    cmp("wrap_x", int'(b_x), 0);
    cmp("wrap_y", int'(b_y), 1);
    cmp("wrap_line_start", int'(b_ls), 1);
    cmp("wrap_frame_start", int'(b_fs), 0);

    // Continuous enable from a fresh reset: line/frame measurements.
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cmp("first_step_frame_start_a", int'(a_fs), 1);
    de_cnt = int'(a_de); hl_cnt = int'(!a_hsync); vs_cnt = int'(b_vs);
    ls_last = cyc; ls_n = 0; fs_last = cyc; fs_n = 0;
    for (int i = 1; i < 1700; i++) begin
      cycle(1'b1, 1'b1);
      if (i < 800) begin
        de_cnt += int'(a_de);
        hl_cnt += int'(!a_hsync);
      end
      if (i < 135) vs_cnt += int'(b_vs);
      if (a_ls) begin
        cmp("a_line_period", cyc - ls_last, 800);
        ls_last = cyc; ls_n++;
      end
      if (b_fs) begin
        cmp("b_frame_period", cyc - fs_last, 135);
        fs_last = cyc; fs_n++;
      end
    end
    cmp("a_de_per_line", de_cnt, 640);
    cmp("a_hsync_low_per_line", hl_cnt, 96);
    cmp("b_vs_per_frame", vs_cnt, 30);
    cmp("a_line_strobes", ls_n, 2);
    cmp("b_frame_strobes", fs_n, 12);

    // Enable every other clock: frame period doubles.
    fs_last = -1; fs_n = 0;
    for (int i = 0; i < 900; i++) begin
      cycle(1'b1, (i % 2) == 1);
      if (b_fs) begin
        if (fs_last >= 0) begin
          cmp("b_frame_period_half", cyc - fs_last, 270);
          fs_n++;
        end
        fs_last = cyc;
      end
    end
    cmp("b_frame_strobes_half", fs_n, 2);

    // Random enable pattern.
    for (int i = 0; i < 3000; i++) cycle(1'b1, $urandom_range(0, 3) != 0);

    // Asynchronous reset mid-line at x=300 of the full-size raster.
    seek = 0;
    while ((pa % 800) != 300 && seek < 2000) begin
      cycle(1'b1, 1'b1);
      seek++;
    end
    cmp("seek_x300", int'(a_x), 300);
    rst_l = 1'b0;
    #1;
    model_reset();
    check_models();
    cmp("rst_imm_x", int'(a_x), 799);
    cmp("rst_imm_y", int'(a_y), 524);
    cmp("rst_imm_hsync", int'(a_hsync), 1);
    cmp("rst_imm_b_hsync", int'(b_hsync), 0);
    @(negedge clk);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    cmp("resume_x", int'(a_x), 0);
    cmp("resume_y", int'(a_y), 0);
    cmp("resume_frame_start", int'(a_fs), 1);
    cycle(1'b1, 1'b0);
    cmp("resume_strobe_clear", int'(a_fs), 0);
    for (int i = 0; i < 400; i++) cycle(1'b1, $urandom_range(0, 1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
